// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Shared, banked data memory serving load/store requests from
//               the M stage of NUM_CORES cores. Each bank has its own
//               round-robin arbiter, so cores hitting different banks are
//               served in the same cycle. A granted access completes at the
//               edge ending the grant cycle; the core sees a one-cycle ready
//               pulse (and load data) in the following cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   1                    rising-edge clock
//   reset            in   1                    synchronous, active-low reset
//   enable_bus       in   2*NUM_CORES          per core {ST,LD}; 01=LD, 10=ST
//   addr_bus         in   ADDR_SIZE*NUM_CORES  per core {bank, word offset}
//   wr_data_bus      in   REG_SIZE*NUM_CORES   per core store data
//   rd_data_bus      out  REG_SIZE*NUM_CORES   per core load data (held until
//                                              the next load completion)
//   ready_bus        out  NUM_CORES            per core completion pulse
//   conflict_cnt_bus out  16*NUM_CORES         per bank saturating count of
//                                              cycles with >1 requester
//                                              (only with the macro below)
// Build option
//   DATA_MEM_RESP_STAT_EN : when defined, adds conflict_cnt_bus and the
//                           per-bank conflict counters.
// ============================================================================
module data_mem_responder #(
    parameter int NUM_CORES    = 4,
    parameter int REG_SIZE     = 8,
    parameter int CORE_ID_SIZE = 2,
    parameter int ADDR_SIZE    = CORE_ID_SIZE + REG_SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2*NUM_CORES-1:0]        enable_bus,
    input  logic [ADDR_SIZE*NUM_CORES-1:0] addr_bus,
    input  logic [REG_SIZE*NUM_CORES-1:0] wr_data_bus,
    output logic [REG_SIZE*NUM_CORES-1:0] rd_data_bus,
    output logic [NUM_CORES-1:0]          ready_bus
`ifdef DATA_MEM_RESP_STAT_EN
    ,
    output logic [16*NUM_CORES-1:0]       conflict_cnt_bus
`endif
);

    localparam int c_DEPTH = 2 ** REG_SIZE;

    // ------------------------------------------------------------------------
    // Per-core request decode
    // ------------------------------------------------------------------------
    logic [NUM_CORES-1:0]    w_is_ld;
    logic [NUM_CORES-1:0]    w_is_st;
    logic [NUM_CORES-1:0]    w_req;
    logic [NUM_CORES-1:0]    w_in_rng;
    logic [NUM_CORES-1:0]    w_oor;
    logic [NUM_CORES-1:0]    w_core_gnt;
    logic [CORE_ID_SIZE-1:0] w_bank  [NUM_CORES];
    logic [REG_SIZE-1:0]     w_off   [NUM_CORES];
    logic [REG_SIZE-1:0]     w_wdata [NUM_CORES];

    // Per-bank results gathered for the core-side registers
    logic [NUM_CORES-1:0]    w_bank_gnt   [NUM_CORES];
    logic [REG_SIZE-1:0]     w_bank_rdata [NUM_CORES];

    // Core-side response registers
    logic [NUM_CORES-1:0]    r_ready;
    logic [REG_SIZE-1:0]     r_rd_data [NUM_CORES];

    // Distance from the round-robin pointer to core k, modulo NUM_CORES.
    // The requester with the smallest distance wins.
    function automatic int f_dist(input int k, input logic [CORE_ID_SIZE-1:0] p);
        int v_p;
        v_p = int'(p);
        if (k >= v_p) begin
            return k - v_p;
        end
        return k + NUM_CORES - v_p;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_is_ld[i]  = (enable_bus[2*i +: 2] == 2'b01);
            w_is_st[i]  = (enable_bus[2*i +: 2] == 2'b10);
            // A core whose ready is high this cycle is finishing its previous
            // access; its still-held enable must not count as a new request.
            w_req[i]    = (w_is_ld[i] | w_is_st[i]) & ~r_ready[i];
            w_bank[i]   = addr_bus[i*ADDR_SIZE + REG_SIZE +: CORE_ID_SIZE];
            w_off[i]    = addr_bus[i*ADDR_SIZE +: REG_SIZE];
            w_wdata[i]  = wr_data_bus[i*REG_SIZE +: REG_SIZE];
            w_in_rng[i] = (int'(w_bank[i]) < NUM_CORES);
            // Out-of-range requests bypass arbitration and complete at once
            w_oor[i]    = w_req[i] & ~w_in_rng[i];
        end
    end

    // ------------------------------------------------------------------------
    // Banks: arbiter, round-robin pointer, storage
    // ------------------------------------------------------------------------
    for (genvar b = 0; b < NUM_CORES; b++) begin : g_bank
        logic [NUM_CORES-1:0]    w_breq;
        logic [NUM_CORES-1:0]    w_gnt;
        logic                    w_gnt_vld;
        logic [CORE_ID_SIZE-1:0] w_gnt_idx;
        int                      w_best_dist;
        logic [REG_SIZE-1:0]     w_acc_off;
        logic [REG_SIZE-1:0]     w_acc_wdata;
        logic                    w_acc_wr;
        logic [CORE_ID_SIZE-1:0] r_rr_ptr;
        logic [REG_SIZE-1:0]     r_mem [c_DEPTH];

        always_comb begin
            for (int i = 0; i < NUM_CORES; i++) begin
                w_breq[i] = w_req[i] & w_in_rng[i] &
                            (w_bank[i] == CORE_ID_SIZE'(b));
            end
        end

        // Round-robin pick; the winning core also steers the bank port.
        always_comb begin
            w_gnt       = '0;
            w_gnt_vld   = 1'b0;
            w_gnt_idx   = '0;
            w_best_dist = NUM_CORES;
            w_acc_off   = '0;
            w_acc_wdata = '0;
            w_acc_wr    = 1'b0;
            for (int k = 0; k < NUM_CORES; k++) begin
                if (w_breq[k] && (f_dist(k, r_rr_ptr) < w_best_dist)) begin
                    w_best_dist = f_dist(k, r_rr_ptr);
                    w_gnt       = '0;
                    w_gnt[k]    = 1'b1;
                    w_gnt_vld   = 1'b1;
                    w_gnt_idx   = CORE_ID_SIZE'(k);
                    w_acc_off   = w_off[k];
                    w_acc_wdata = w_wdata[k];
                    w_acc_wr    = w_is_st[k];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_rr_ptr <= '0;
            end else if (w_gnt_vld) begin
                if (int'(w_gnt_idx) == NUM_CORES - 1) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= w_gnt_idx + CORE_ID_SIZE'(1);
                end
            end
        end

        // Storage is never cleared; a store whose grant cycle ends on a reset
        // edge is suppressed.
        always_ff @(posedge clk) begin
            if (reset && w_gnt_vld && w_acc_wr) begin
                r_mem[w_acc_off] <= w_acc_wdata;
            end
        end

        // Read port follows the granted address; the core-side register
        // captures it at the same edge, giving a synchronous read.
        assign w_bank_rdata[b] = r_mem[w_acc_off];
        assign w_bank_gnt[b]   = w_gnt;

`ifdef DATA_MEM_RESP_STAT_EN
        logic [15:0] r_conf_cnt;
        logic        w_multi;

        // More than one bit set: clearing the lowest set bit leaves a residue
        assign w_multi = |(w_breq & (w_breq - NUM_CORES'(1)));

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_conf_cnt <= '0;
            end else if (w_multi && (r_conf_cnt != 16'hFFFF)) begin
                r_conf_cnt <= r_conf_cnt + 16'd1;
            end
        end

        assign conflict_cnt_bus[b*16 +: 16] = r_conf_cnt;
`endif
    end

    // ------------------------------------------------------------------------
    // Core-side response registers
    // ------------------------------------------------------------------------
    always_comb begin
        w_core_gnt = '0;
        for (int b = 0; b < NUM_CORES; b++) begin
            w_core_gnt = w_core_gnt | w_bank_gnt[b];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ready <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_rd_data[i] <= '0;
            end
        end else begin
            r_ready <= w_core_gnt | w_oor;
            for (int i = 0; i < NUM_CORES; i++) begin
                // Load data is held until this core's next load completes
                if (w_core_gnt[i] && w_is_ld[i]) begin
                    r_rd_data[i] <= w_bank_rdata[w_bank[i]];
                end else if (w_oor[i] && w_is_ld[i]) begin
                    r_rd_data[i] <= '0;
                end
            end
        end
    end

    assign ready_bus = r_ready;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_out
        assign rd_data_bus[i*REG_SIZE +: REG_SIZE] = r_rd_data[i];
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Shared, banked data memory that answers the load/store requests issued by the cores' M stage.
- Each core drives an enable/addr/wr_data request. The responder returns rd_data plus a one-cycle ready pulse, which releases the core's M-stage block.
- Address high bits {CORE_ID_SIZE} select a bank; low bits {REG_SIZE} select the word.
- Every bank has its own round-robin arbiter, so cores hitting different banks are served in parallel.

Parameters:
- NUM_CORES, 4, number of requesting cores; also the number of banks.
- REG_SIZE, 8, data width and word-offset width.
- CORE_ID_SIZE, 2, bank-select width; NUM_CORES <= 2**CORE_ID_SIZE.
- ADDR_SIZE, CORE_ID_SIZE+REG_SIZE, request address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- enable_bus  in  2*NUM_CORES  per core {ST,LD}: 2'b01 = LD, 2'b10 = ST, 2'b00/2'b11 = no request.
- addr_bus  in  ADDR_SIZE*NUM_CORES  per core {bank, offset}.
- wr_data_bus  in  REG_SIZE*NUM_CORES  per core store data.
- rd_data_bus  out  REG_SIZE*NUM_CORES  per core load data; valid while that core's ready is 1.
- ready_bus  out  NUM_CORES  per core completion pulse.

Behaviour:
- Core i field = bits [i*W +: W] of each bus.
- **Request.** Core i requests when its enable is 01 or 10 and ready_bus[i] is 0 in that cycle. Outside those conditions it is not a requester. While ready_bus[i] is 1, the core's still-held enable is ignored.
- **Bank selection.** Bank b = addr[ADDR_SIZE-1 -: CORE_ID_SIZE]. A bank index >= NUM_CORES is out of range:
  - LD returns 0, ST is dropped.
  - Ready still pulses with 1-cycle latency, with no arbitration.
- **Arbitration (cycle t, combinational per bank).**
  - Grant goes to the lowest index k >= rr_ptr[b] among requesters of bank b, wrapping modulo NUM_CORES.
  - At most one grant per bank per cycle.
  - On a grant, rr_ptr[b] <= (k+1) mod NUM_CORES; with no grant, rr_ptr[b] holds.
- **Access (edge ending cycle t).**
  - ST: mem[b][offset] <= wr_data.
  - LD: rd_data_r[k] <= mem[b][offset] (synchronous read).
  - Granted core: ready_r[k] <= 1. Every other core: ready_r <= 0.
- **Response (cycle t+1).**
  - ready_bus[k] = 1 for exactly one cycle.
  - rd_data_bus[k] holds the read word; for ST it is don't-care.
  - rd_data_bus[k] holds its value until the next LD completion for that core.
- **Latency.** Minimum 1 cycle from request to ready. A losing core keeps requesting and waits; its worst-case wait is NUM_CORES cycles.
- **Back-to-back.** Enable still asserted in cycle t+2 is a new request and is served again; the core has advanced to a new instruction by then.
- **Per-bank-port coherence.**
  - ST and LD to the same word in consecutive grants: the LD sees the stored value.
  - Same-cycle hazards cannot occur, because a bank serves one access per cycle.
- **Reset (reset == 0 at a rising edge).**
  - ready_bus = 0, rd_data_bus = 0, all rr_ptr = 0.
  - Any write whose grant cycle ends on a reset edge is suppressed.
  - Memory contents are not cleared.
  - An in-flight request is dropped: no ready is issued; the core re-requests after reset.
- **Storage.** Memory is NUM_CORES banks of 2**REG_SIZE words; no initialisation is required.

Optional Feature:
- Macro: DATA_MEM_RESP_STAT_EN.
- **Defined.**
  - Adds output conflict_cnt_bus (16*NUM_CORES bits).
  - Per bank: a 16-bit saturating count of cycles in which the bank had more than one requester.
  - Cleared on reset; holds at 16'hFFFF when saturated.
- **Undefined.** The port and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset low 2 cycles, then high with no enables -> ready_bus = 0, rd_data_bus = 0 every cycle.
- Core0 ST addr {1,8'h10} data 8'hA5 (cycle 0), then LD of the same address -> ready_bus[0] pulses in cycles 1 and 3; rd_data core0 = 8'hA5 in cycle 3.
- Cores 0, 1, 2 all LD bank 2 in cycle 0 and hold until ready -> ready for core0 at cycle 1, core1 at cycle 2, core2 at cycle 3; rr_ptr[2] = 3 afterwards.
- Core0 to bank 0 and core3 to bank 3, same cycle -> both ready in cycle 1 (parallel banks).
- Core1 holds ST of 8'h3C to {0,8'h00}; reset driven low on the edge ending its grant cycle -> no ready; word unchanged when read back after reset.
- Macro defined: cores 0 and 1 contend on bank 1 for 3 cycles -> conflict_cnt for bank 1 = 1 (cycle 0 only; core0 is excluded by its ready in cycle 1, so cycle 1 has a single requester). Also preload conflict_cnt to 16'hFFFF -> it stays at 16'hFFFF.
